// File: rtl/gate_seq_pkg.sv
// Shared types and sizes for the gate truth-table sequencer.
package gate_seq_pkg;

  localparam int unsigned NUM_VECTORS = 4;
  localparam int unsigned VEC_W       = 2;
  localparam int unsigned ERR_W       = 3;
  localparam int unsigned TMR_W       = 4;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StSettle,
    StSample,
    StFinish
  } state_e;

endpackage

// File: rtl/gate_truth_sequencer_if.sv
// Signal bundle between the sequencer and whoever starts runs and hosts the gate.
interface gate_truth_sequencer_if;
  import gate_seq_pkg::*;

  logic                   start;
  logic [NUM_VECTORS-1:0] expect_tt;
  logic                   y;
  logic                   a;
  logic                   b;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [NUM_VECTORS-1:0] err_mask;
  logic [ERR_W-1:0]       err_count;

  // Controller / gate side
  modport master (
    output start, expect_tt, y,
    input  a, b, busy, done, pass, err_mask, err_count
  );

  // Sequencer side
  modport slave (
    input  start, expect_tt, y,
    output a, b, busy, done, pass, err_mask, err_count
  );
endinterface

// File: rtl/gate_truth_sequencer_settle_timer.sv
// Loadable down-counter that times the settle window of each vector.
module settle_timer
  import gate_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [TMR_W-1:0] r_cnt;

  // Load takes priority; decrement saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/gate_truth_sequencer.sv
// Drives all four input vectors onto a 2-input gate, samples its output after a
// settle window and compares against a latched expected truth table.
module gate_truth_sequencer
  import gate_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic                   clk,
  input logic                   rst,
  gate_truth_sequencer_if.slave bus
);

  // SETTLE lasts SETTLE_CYCLES cycles, counting SETTLE_CYCLES-1 down to 0.
  localparam logic [TMR_W-1:0] LP_LOAD =
      (SETTLE_CYCLES == 0) ? '0 : TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] LP_LAST_VEC = VEC_W'(NUM_VECTORS - 1);

  state_e                 r_state, w_state_d;
  logic [VEC_W-1:0]       r_vec, w_vec_d;
  logic [NUM_VECTORS-1:0] r_expect, w_expect_d;
  logic [NUM_VECTORS-1:0] r_err_mask, w_err_mask_d;
  logic [ERR_W-1:0]       r_err_count, w_err_count_d;
  logic                   r_pass, w_pass_d;
  logic [VEC_W-1:0]       r_ab, w_ab_d;
  logic                   w_load;
  logic                   w_dec;
  logic                   w_zero;

  settle_timer u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (LP_LOAD),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_vec       <= '0;
      r_expect    <= '0;
      r_err_mask  <= '0;
      r_err_count <= '0;
      r_pass      <= 1'b0;
      r_ab        <= '0;
    end else begin
      r_state     <= w_state_d;
      r_vec       <= w_vec_d;
      r_expect    <= w_expect_d;
      r_err_mask  <= w_err_mask_d;
      r_err_count <= w_err_count_d;
      r_pass      <= w_pass_d;
      r_ab        <= w_ab_d;
    end
  end

  // Next-state, result update and timer control.
  always_comb begin
    w_state_d     = r_state;
    w_vec_d       = r_vec;
    w_expect_d    = r_expect;
    w_err_mask_d  = r_err_mask;
    w_err_count_d = r_err_count;
    w_pass_d      = r_pass;
    w_load        = 1'b0;
    w_dec         = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_state_d     = StDrive;
          w_vec_d       = '0;
          w_expect_d    = bus.expect_tt;
          w_err_mask_d  = '0;
          w_err_count_d = '0;
          w_pass_d      = 1'b0;
        end
      end
      StDrive: begin
        w_load    = 1'b1;
        w_state_d = (SETTLE_CYCLES == 0) ? StSample : StSettle;
      end
      StSettle: begin
        w_dec = 1'b1;
        if (w_zero) begin
          w_state_d = StSample;
        end
      end
      StSample: begin
        if (bus.y != r_expect[r_vec]) begin
          w_err_mask_d[r_vec] = 1'b1;
          w_err_count_d       = r_err_count + 1'b1;
        end
        if (r_vec == LP_LAST_VEC) begin
          w_state_d = StFinish;
          // Uses the next mask so the final sample counts.
          w_pass_d  = (w_err_mask_d == '0);
        end else begin
          w_vec_d   = r_vec + 1'b1;
          w_state_d = StDrive;
        end
      end
      StFinish: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Gate inputs carry the vector only while a vector is being exercised.
  always_comb begin
    w_ab_d = '0;
    if ((w_state_d == StDrive) || (w_state_d == StSettle) || (w_state_d == StSample)) begin
      w_ab_d = w_vec_d;
    end
  end

  assign bus.a         = r_ab[1];
  assign bus.b         = r_ab[0];
  assign bus.busy      = (r_state != StIdle);
  assign bus.done      = (r_state == StFinish);
  assign bus.pass      = r_pass;
  assign bus.err_mask  = r_err_mask;
  assign bus.err_count = r_err_count;

endmodule
